// File: rtl/first_nios2_system_pkg.sv
// Shared types and constants for the system ID checker and its Avalon read master.
package first_nios2_system_pkg;

    localparam int SYSID_ADDR_W = 1;
    localparam int SYSID_DATA_W = 32;
    localparam int TMO_CNT_W    = 16;
    localparam int STATE_W      = 3;

    localparam logic [SYSID_ADDR_W-1:0] SYSID_ADDR_ID = 1'b0;
    localparam logic [SYSID_ADDR_W-1:0] SYSID_ADDR_TS = 1'b1;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_ID_REQ = 3'd1,
        ST_ID_LAT = 3'd2,
        ST_TS_REQ = 3'd3,
        ST_TS_LAT = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

endpackage

// File: rtl/first_nios2_system_avalon_read_master.sv
// Single-word Avalon-MM read handshake: request phase with stall timeout,
// then a fixed-latency wait before the returned word is valid.
//
// Handshake: sysid_read is held high with a stable sysid_address for as long
// as the caller keeps req_active; the read is accepted in the first cycle in
// which sysid_read=1 and sysid_waitrequest=0. With zero latency the data is
// valid in that same cycle, otherwise it is valid in the READ_LATENCY-th
// lat_active cycle after the accept. At most one read is ever outstanding.
module first_nios2_system_avalon_read_master
    import first_nios2_system_pkg::*;
#(
    parameter int READ_LATENCY   = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    req_active,
    input  logic                    lat_active,
    input  logic [SYSID_ADDR_W-1:0] word_addr,
    output logic [SYSID_ADDR_W-1:0] sysid_address,
    output logic                    sysid_read,
    input  logic [SYSID_DATA_W-1:0] sysid_readdata,
    input  logic                    sysid_waitrequest,
    output logic                    accepted,
    output logic                    data_valid,
    output logic [SYSID_DATA_W-1:0] data,
    output logic                    timed_out
);

    localparam logic [TMO_CNT_W-1:0] WAIT_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]           LAT_LAST  = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);

    logic [TMO_CNT_W-1:0] wait_cnt;
    logic [1:0]           lat_cnt;

    assign sysid_read    = req_active;
    assign sysid_address = req_active ? word_addr : SYSID_ADDR_ID;
    assign accepted      = req_active && !sysid_waitrequest;
    assign timed_out     = req_active && sysid_waitrequest && (wait_cnt == WAIT_LAST);
    assign data_valid    = (READ_LATENCY == 0) ? accepted : (lat_active && (lat_cnt == LAT_LAST));
    assign data          = sysid_readdata;

    // Count stalled request cycles; cleared on accept, on timeout and outside a request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (req_active && sysid_waitrequest && !timed_out) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Count cycles spent waiting for fixed-latency read data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lat_cnt <= '0;
        end else if (lat_active) begin
            lat_cnt <= lat_cnt + 1'b1;
        end else begin
            lat_cnt <= '0;
        end
    end

endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// Reads the system ID and build timestamp words, compares them against the
// expected values and reports pass/fail/timeout status.
module first_nios2_system_sysid_checker
    import first_nios2_system_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1363709509,
    parameter int          READ_LATENCY       = 0,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          AUTO_START         = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    output logic [SYSID_ADDR_W-1:0] sysid_address,
    output logic                    sysid_read,
    input  logic [SYSID_DATA_W-1:0] sysid_readdata,
    input  logic                    sysid_waitrequest,
    output logic                    busy,
    output logic                    done,
    output logic                    id_ok,
    output logic                    ts_ok,
    output logic                    timeout,
    output logic [SYSID_DATA_W-1:0] id_value,
    output logic [SYSID_DATA_W-1:0] ts_value,
    output logic [STATE_W-1:0]      dbg_state
);

    state_e                  state_q;
    state_e                  state_d;
    logic                    auto_q;
    logic                    launch;
    logic                    req_active;
    logic                    lat_active;
    logic                    in_id;
    logic [SYSID_ADDR_W-1:0] word_addr;
    logic                    rm_accepted;
    logic                    rm_data_valid;
    logic                    rm_timed_out;
    logic [SYSID_DATA_W-1:0] rm_data;

    assign req_active = (state_q == ST_ID_REQ) || (state_q == ST_TS_REQ);
    assign lat_active = (state_q == ST_ID_LAT) || (state_q == ST_TS_LAT);
    assign in_id      = (state_q == ST_ID_REQ) || (state_q == ST_ID_LAT);
    assign word_addr  = in_id ? SYSID_ADDR_ID : SYSID_ADDR_TS;
    assign dbg_state  = state_q;

    first_nios2_system_avalon_read_master #(
        .READ_LATENCY   (READ_LATENCY),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_read_master (
        .clock             (clock),
        .reset_n           (reset_n),
        .req_active        (req_active),
        .lat_active        (lat_active),
        .word_addr         (word_addr),
        .sysid_address     (sysid_address),
        .sysid_read        (sysid_read),
        .sysid_readdata    (sysid_readdata),
        .sysid_waitrequest (sysid_waitrequest),
        .accepted          (rm_accepted),
        .data_valid        (rm_data_valid),
        .data              (rm_data),
        .timed_out         (rm_timed_out)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: sequence the ID read then the timestamp read; start only counts when idle or done.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start || auto_q) begin
                    launch  = 1'b1;
                    state_d = ST_ID_REQ;
                end
            end
            ST_ID_REQ: begin
                if (rm_timed_out) begin
                    state_d = ST_DONE;
                end else if (rm_accepted) begin
                    state_d = (READ_LATENCY == 0) ? ST_TS_REQ : ST_ID_LAT;
                end
            end
            ST_ID_LAT: begin
                if (rm_data_valid) begin
                    state_d = ST_TS_REQ;
                end
            end
            ST_TS_REQ: begin
                if (rm_timed_out) begin
                    state_d = ST_DONE;
                end else if (rm_accepted) begin
                    state_d = (READ_LATENCY == 0) ? ST_DONE : ST_TS_LAT;
                end
            end
            ST_TS_LAT: begin
                if (rm_data_valid) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    launch  = 1'b1;
                    state_d = ST_ID_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered status, captured words and compare results.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            auto_q   <= (AUTO_START != 0);
            busy     <= 1'b0;
            done     <= 1'b0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
        end else begin
            auto_q <= 1'b0;
            busy   <= (state_d != ST_IDLE) && (state_d != ST_DONE);
            done   <= (state_d == ST_DONE);
            if (launch) begin
                id_ok    <= 1'b0;
                ts_ok    <= 1'b0;
                timeout  <= 1'b0;
                id_value <= '0;
                ts_value <= '0;
            end else begin
                if (rm_data_valid && in_id) begin
                    id_value <= rm_data;
                    id_ok    <= (rm_data == EXPECTED_ID);
                end
                if (rm_data_valid && !in_id) begin
                    ts_value <= rm_data;
                    ts_ok    <= (rm_data == EXPECTED_TIMESTAMP);
                end
                if (rm_timed_out) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Bench for the system ID checker: three instances (defaults, short timeout,
// read latency 2), each with its own behavioural Avalon slave.
module tb_first_nios2_system_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1363709509;
    localparam int          BUDGET = 400;

    // clock / reset
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_n   [3];
    logic        start   [3];
    logic        addr    [3];
    logic        rd      [3];
    logic [31:0] rdata   [3];
    logic        wreq    [3];
    logic        busy    [3];
    logic        done    [3];
    logic        id_ok   [3];
    logic        ts_ok   [3];
    logic        tmo     [3];
    logic [31:0] id_v    [3];
    logic [31:0] ts_v    [3];
    logic [2:0]  dbg     [3];

    // slave configuration and observation
    logic [31:0] mem_id    [3];
    logic [31:0] mem_ts    [3];
    int          stall_id  [3];
    int          stall_ts  [3];
    int          wr_cnt    [3];
    int          acc_cnt   [3];
    int          ts_issued [3];
    bit          p1_v [3];
    bit          p2_v [3];
    bit          p1_a [3];
    bit          p2_a [3];

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    first_nios2_system_sysid_checker dut0 (
        .clock(clock), .reset_n(rst_n[0]), .start(start[0]),
        .sysid_address(addr[0]), .sysid_read(rd[0]), .sysid_readdata(rdata[0]),
        .sysid_waitrequest(wreq[0]), .busy(busy[0]), .done(done[0]), .id_ok(id_ok[0]),
        .ts_ok(ts_ok[0]), .timeout(tmo[0]), .id_value(id_v[0]), .ts_value(ts_v[0]),
        .dbg_state(dbg[0])
    );

    first_nios2_system_sysid_checker #(.TIMEOUT_CYCLES(4)) dut1 (
        .clock(clock), .reset_n(rst_n[1]), .start(start[1]),
        .sysid_address(addr[1]), .sysid_read(rd[1]), .sysid_readdata(rdata[1]),
        .sysid_waitrequest(wreq[1]), .busy(busy[1]), .done(done[1]), .id_ok(id_ok[1]),
        .ts_ok(ts_ok[1]), .timeout(tmo[1]), .id_value(id_v[1]), .ts_value(ts_v[1]),
        .dbg_state(dbg[1])
    );

    first_nios2_system_sysid_checker #(.READ_LATENCY(2)) dut2 (
        .clock(clock), .reset_n(rst_n[2]), .start(start[2]),
        .sysid_address(addr[2]), .sysid_read(rd[2]), .sysid_readdata(rdata[2]),
        .sysid_waitrequest(wreq[2]), .busy(busy[2]), .done(done[2]), .id_ok(id_ok[2]),
        .ts_ok(ts_ok[2]), .timeout(tmo[2]), .id_value(id_v[2]), .ts_value(ts_v[2]),
        .dbg_state(dbg[2])
    );

    // Slave model: stall each read for a configured number of cycles; instance 2
    // returns data only in the second cycle after accept (junk otherwise).
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            wreq[k] = rd[k] && (wr_cnt[k] < (addr[k] ? stall_ts[k] : stall_id[k]));
            if (k == 2) rdata[k] = p2_v[k] ? (p2_a[k] ? mem_ts[k] : mem_id[k]) : 32'hDEAD_BEEF;
            else        rdata[k] = addr[k] ? mem_ts[k] : mem_id[k];
        end
    end

    always @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (rd[k] && wreq[k]) wr_cnt[k] <= wr_cnt[k] + 1;
            else                  wr_cnt[k] <= 0;
            if (rd[k] && !wreq[k]) acc_cnt[k] <= acc_cnt[k] + 1;
            if (rd[k] && addr[k])  ts_issued[k] <= ts_issued[k] + 1;
            p1_v[k] <= rd[k] && !wreq[k];
            p1_a[k] <= addr[k];
            p2_v[k] <= p1_v[k];
            p2_a[k] <= p1_a[k];
        end
    end

    // reference model: cycles spent on one word (stall, then accept, then latency)
    function automatic int word_cost(int stall, int lim, int lat);
        return (stall >= lim) ? lim : stall + 1 + lat;
    endfunction

    // driver: counts edges from the launch edge until done is seen
    task automatic wait_done(input int k, output int cycles);
        cycles = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge clock);
            #1;
            start[k] = 1'b0;
            cycles++;
            if (done[k]) break;
        end
        n_checks++;
        if (done[k] !== 1'b1) begin
            n_errors++;
            $display("FAIL wait_done[%0d]: done=%b after %0d cycles, required 1", k, done[k], cycles);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({busy[k], done[k], id_ok[k], ts_ok[k], tmo[k], rd[k], addr[k], dbg[k]} !== 10'b0) begin
                n_errors++;
                $display("FAIL reset_flags[%0d]: got %b required 0", k,
                         {busy[k], done[k], id_ok[k], ts_ok[k], tmo[k], rd[k], addr[k], dbg[k]});
            end
            n_checks++;
            if (id_v[k] !== 32'd0 || ts_v[k] !== 32'd0) begin
                n_errors++;
                $display("FAIL reset_values[%0d]: id=%h ts=%h required 0", k, id_v[k], ts_v[k]);
            end
        end
    endtask

    task automatic test_defaults();
        int cyc;
        int a0;
        a0 = acc_cnt[0];
        @(negedge clock);
        rst_n[0] = 1'b1;
        wait_done(0, cyc);
        n_checks++;
        if (cyc !== 3) begin n_errors++; $display("FAIL defaults_cycles: got %0d required 3", cyc); end
        n_checks++;
        if ({id_ok[0], ts_ok[0], tmo[0], busy[0]} !== 4'b1100) begin
            n_errors++; $display("FAIL defaults_flags: got %b required 1100", {id_ok[0], ts_ok[0], tmo[0], busy[0]});
        end
        n_checks++;
        if (id_v[0] !== EXP_ID || ts_v[0] !== EXP_TS) begin
            n_errors++; $display("FAIL defaults_values: id=%h ts=%h required %h %h", id_v[0], ts_v[0], EXP_ID, EXP_TS);
        end
        n_checks++;
        if (acc_cnt[0] - a0 !== 2) begin n_errors++; $display("FAIL defaults_reads: got %0d required 2", acc_cnt[0] - a0); end
    endtask

    task automatic test_id_mismatch();
        int cyc;
        mem_id[0] = 32'h1;
        @(negedge clock);
        start[0] = 1'b1;
        wait_done(0, cyc);
        n_checks++;
        if (cyc !== 3) begin n_errors++; $display("FAIL mismatch_cycles: got %0d required 3", cyc); end
        n_checks++;
        if ({id_ok[0], ts_ok[0], tmo[0]} !== 3'b010) begin
            n_errors++; $display("FAIL mismatch_flags: got %b required 010", {id_ok[0], ts_ok[0], tmo[0]});
        end
        n_checks++;
        if (id_v[0] !== 32'h1) begin n_errors++; $display("FAIL mismatch_id_value: got %h required 00000001", id_v[0]); end
    endtask

    task automatic test_stall();
        int cyc;
        int a0;
        mem_id[0]   = EXP_ID;
        stall_id[0] = 10;
        stall_ts[0] = 10;
        a0 = acc_cnt[0];
        @(negedge clock);
        start[0] = 1'b1;
        wait_done(0, cyc);
        n_checks++;
        if (cyc !== 23) begin n_errors++; $display("FAIL stall_cycles: got %0d required 23", cyc); end
        n_checks++;
        if (acc_cnt[0] - a0 !== 2) begin n_errors++; $display("FAIL stall_reads: got %0d required 2", acc_cnt[0] - a0); end
        n_checks++;
        if ({id_ok[0], ts_ok[0], tmo[0]} !== 3'b110) begin
            n_errors++; $display("FAIL stall_flags: got %b required 110", {id_ok[0], ts_ok[0], tmo[0]});
        end
        stall_id[0] = 0;
        stall_ts[0] = 0;
    endtask

    task automatic test_timeout();
        int cyc;
        int t0;
        stall_id[1] = 1000;
        t0 = ts_issued[1];
        @(negedge clock);
        rst_n[1] = 1'b1;
        wait_done(1, cyc);
        n_checks++;
        if (cyc !== 5) begin n_errors++; $display("FAIL timeout_cycles: got %0d required 5", cyc); end
        n_checks++;
        if ({tmo[1], done[1], rd[1], id_ok[1], ts_ok[1]} !== 5'b11000) begin
            n_errors++; $display("FAIL timeout_flags: got %b required 11000", {tmo[1], done[1], rd[1], id_ok[1], ts_ok[1]});
        end
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (ts_issued[1] - t0 !== 0 || rd[1] !== 1'b0 || id_v[1] !== 32'd0) begin
            n_errors++; $display("FAIL timeout_no_ts_read: ts_reads=%0d read=%b id=%h required 0 0 0", ts_issued[1] - t0, rd[1], id_v[1]);
        end
        stall_id[1] = 0;
    endtask

    task automatic test_latency();
        int cyc;
        @(negedge clock);
        rst_n[2] = 1'b1;
        wait_done(2, cyc);
        n_checks++;
        if (cyc !== 7) begin n_errors++; $display("FAIL latency_cycles: got %0d required 7", cyc); end
        n_checks++;
        if ({id_ok[2], ts_ok[2], tmo[2]} !== 3'b110 || id_v[2] !== EXP_ID || ts_v[2] !== EXP_TS) begin
            n_errors++; $display("FAIL latency_capture: flags=%b id=%h ts=%h required 110 %h %h",
                                 {id_ok[2], ts_ok[2], tmo[2]}, id_v[2], ts_v[2], EXP_ID, EXP_TS);
        end
    endtask

    // Random words and stalls; expected results come from the word-level model via exp_q.
    task automatic test_random(input int k, input int lim, input int lat, input int max_stall, input int iters);
        int cyc;
        int s_id;
        int s_ts;
        bit id_to;
        bit ts_to;
        logic [31:0] e;
        for (int it = 0; it < iters; it++) begin
            s_id = $urandom_range(0, max_stall);
            s_ts = $urandom_range(0, max_stall);
            mem_id[k]   = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom();
            mem_ts[k]   = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom();
            stall_id[k] = s_id;
            stall_ts[k] = s_ts;
            id_to = (s_id >= lim);
            ts_to = !id_to && (s_ts >= lim);
            exp_q.push_back(32'(1 + word_cost(s_id, lim, lat) + (id_to ? 0 : word_cost(s_ts, lim, lat))));
            exp_q.push_back({29'd0, id_to | ts_to, !id_to && (mem_id[k] == EXP_ID),
                             !id_to && !ts_to && (mem_ts[k] == EXP_TS)});
            exp_q.push_back(id_to ? 32'd0 : mem_id[k]);
            exp_q.push_back((id_to || ts_to) ? 32'd0 : mem_ts[k]);
            @(negedge clock);
            start[k] = 1'b1;
            wait_done(k, cyc);
            e = exp_q.pop_front();
            n_checks++;
            if (32'(cyc) !== e) begin n_errors++; $display("FAIL rand%0d_cycles it=%0d: got %0d required %0d", k, it, cyc, e); end
            e = exp_q.pop_front();
            n_checks++;
            if ({tmo[k], id_ok[k], ts_ok[k]} !== e[2:0]) begin
                n_errors++; $display("FAIL rand%0d_flags it=%0d: got %b required %b", k, it, {tmo[k], id_ok[k], ts_ok[k]}, e[2:0]);
            end
            e = exp_q.pop_front();
            n_checks++;
            if (id_v[k] !== e) begin n_errors++; $display("FAIL rand%0d_id it=%0d: got %h required %h", k, it, id_v[k], e); end
            e = exp_q.pop_front();
            n_checks++;
            if (ts_v[k] !== e) begin n_errors++; $display("FAIL rand%0d_ts it=%0d: got %h required %h", k, it, ts_v[k], e); end
        end
        mem_id[k]   = EXP_ID;
        mem_ts[k]   = EXP_TS;
        stall_id[k] = 0;
        stall_ts[k] = 0;
    endtask

    task automatic test_reset_mid_and_start();
        int cyc;
        int a0;
        bit found;
        // reset while the timestamp read is stalled
        stall_ts[0] = 1000;
        found = 1'b0;
        @(negedge clock);
        start[0] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock);
            #1;
            start[0] = 1'b0;
            if (rd[0] && addr[0]) begin found = 1'b1; break; end
        end
        n_checks++;
        if (!found) begin n_errors++; $display("FAIL midreset_ts_req: timestamp read not seen, required seen"); end
        repeat (2) @(posedge clock);
        #2;
        rst_n[0] = 1'b0;
        #1;
        n_checks++;
        if ({busy[0], done[0], id_ok[0], ts_ok[0], tmo[0], rd[0], addr[0]} !== 7'b0 || id_v[0] !== 32'd0) begin
            n_errors++; $display("FAIL midreset_clear: flags=%b id=%h required 0 0",
                                 {busy[0], done[0], id_ok[0], ts_ok[0], tmo[0], rd[0], addr[0]}, id_v[0]);
        end
        stall_ts[0] = 0;
        @(negedge clock);
        @(negedge clock);
        rst_n[0] = 1'b1;
        wait_done(0, cyc);
        n_checks++;
        if (cyc !== 3 || {id_ok[0], ts_ok[0]} !== 2'b11) begin
            n_errors++; $display("FAIL midreset_relaunch: cycles=%0d ok=%b required 3 11", cyc, {id_ok[0], ts_ok[0]});
        end
        // start pulse while busy is ignored
        stall_id[0] = 5;
        stall_ts[0] = 5;
        a0 = acc_cnt[0];
        @(negedge clock);
        start[0] = 1'b1;
        cyc = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge clock);
            #1;
            start[0] = 1'b0;
            cyc++;
            if (done[0]) break;
            if (cyc == 4) begin @(negedge clock); start[0] = 1'b1; end
        end
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (cyc !== 13) begin n_errors++; $display("FAIL busy_start_cycles: got %0d required 13", cyc); end
        n_checks++;
        if (acc_cnt[0] - a0 !== 2 || done[0] !== 1'b1 || busy[0] !== 1'b0) begin
            n_errors++; $display("FAIL busy_start_ignored: reads=%0d done=%b busy=%b required 2 1 0", acc_cnt[0] - a0, done[0], busy[0]);
        end
        // start pulse in DONE clears flags and reruns
        stall_id[0] = 0;
        stall_ts[0] = 0;
        @(negedge clock);
        start[0] = 1'b1;
        @(posedge clock);
        #1;
        start[0] = 1'b0;
        n_checks++;
        if ({done[0], busy[0], id_ok[0], ts_ok[0], tmo[0]} !== 5'b01000) begin
            n_errors++; $display("FAIL done_start_clear: got %b required 01000", {done[0], busy[0], id_ok[0], ts_ok[0], tmo[0]});
        end
        wait_done(0, cyc);
        n_checks++;
        if (cyc !== 2 || {id_ok[0], ts_ok[0], tmo[0]} !== 3'b110) begin
            n_errors++; $display("FAIL done_start_rerun: cycles=%0d flags=%b required 2 110", cyc, {id_ok[0], ts_ok[0], tmo[0]});
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k]    = 1'b0;
            start[k]    = 1'b0;
            mem_id[k]   = EXP_ID;
            mem_ts[k]   = EXP_TS;
            stall_id[k] = 0;
            stall_ts[k] = 0;
        end
        repeat (3) @(posedge clock);
        test_reset();
        test_defaults();
        test_id_mismatch();
        test_stall();
        test_random(0, 255, 0, 8, 8);
        test_timeout();
        test_random(1, 4, 0, 6, 10);
        test_latency();
        test_random(2, 255, 2, 4, 6);
        test_reset_mid_and_start();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
